ysyx_22040750_pc_fetch: RTL and testbench
=========================================

// Module: ysyx_22040750_pc_fetch
// PURPOSE
//  Consumer end of the dnpc valid/ready link: owns the architectural PC, accepts the
//  next PC from the next-PC unit, issues one instruction read at a time to the
//  instruction bus, and presents {pc, snpc, inst} to the IF/ID register with valid/ready.
//  Supports flush (redirect kill) with at most one outstanding fetch.
// PARAMETERS
//  RESET_PC  32'h8000_0000  first fetch address after reset release
//  NOP_INST  32'h0000_0013  instruction word presented when O_fault=1
// PORTS
//  I_clk             in   1   clock; everything on posedge
//  I_rst_n           in   1   asynchronous, active-low reset
//  I_dnpc            in   32  next PC from next-PC unit
//  I_dnpc_valid      in   1   I_dnpc valid
//  O_dnpc_ready      out  1   block accepts I_dnpc this cycle
//  I_flush           in   1   kill current/held/in-flight instruction
//  O_imem_req_valid  out  1   read request valid
//  I_imem_req_ready  in   1   bus accepts request
//  O_imem_addr       out  32  read address (= O_pc)
//  I_imem_rsp_valid  in   1   read data valid
//  O_imem_rsp_ready  out  1   block accepts read data
//  I_imem_rsp_data   in   32  instruction word
//  I_imem_rsp_err    in   1   bus error with response
//  O_IF_ID_valid     out  1   fetched instruction valid
//  I_IF_ID_ready     in   1   IF/ID accepts
//  O_pc              out  32  PC of presented/fetching instruction
//  O_snpc            out  32  O_pc + 4, mod 2^32
//  O_inst            out  32  instruction word
//  O_fault           out  1   misaligned PC or bus error for presented instruction
// BEHAVIOUR
//  Reset (async assert, sync release): state=REQ, pc_q=RESET_PC, inst_q=0, fault_q=0,
//   drop_q=0; while I_rst_n=0 all valid/ready outputs are 0. First request 1 cycle after release.
//  States REQ, WAIT, HOLD, NEXT; all outputs decode from registers except O_IF_ID_valid.
//  REQ : O_imem_req_valid=1, addr=pc_q, held stable until I_imem_req_ready -> WAIT.
//  WAIT: O_imem_rsp_ready=1. On I_imem_rsp_valid: drop_q=1 -> discard, clear drop_q, NEXT;
//        else inst_q<=err?NOP_INST:data, fault_q<=err -> HOLD.
//  HOLD: O_IF_ID_valid = ~I_flush. Handshake (valid&ready) -> NEXT. Data held stable while stalled.
//  NEXT: O_dnpc_ready=1. On I_dnpc_valid: pc_q<=I_dnpc; if I_dnpc[1:0]!=0 then
//        inst_q<=NOP_INST, fault_q<=1, no bus request -> HOLD; else fault_q<=0 -> REQ.
//  O_dnpc_ready=0 in REQ/WAIT/HOLD; the producer holds dnpc until accepted.
//  Flush: REQ -> set drop_q, request stays asserted (no withdrawal); WAIT -> set drop_q;
//   HOLD -> discard held instruction, -> NEXT (flush beats same-cycle IF/ID ready);
//   NEXT -> no effect; same-cycle I_dnpc_valid is accepted normally.
//  Flush in WAIT in the same cycle as rsp_valid: response discarded -> NEXT.
//  Latency: dnpc accepted at cycle t -> req_valid at t+1 -> with zero-wait bus
//   (ready=1, rsp the cycle after req handshake) O_IF_ID_valid at t+3.
//  O_snpc = pc_q + 32'd4; 32'hFFFF_FFFC wraps to 0. Bus never sees a misaligned address.
//  Only one request outstanding; no new request before its response.
// TESTING
//  1 Reset release, bus zero-wait, inst 32'h00000297 -> req addr 8000_0000 at cycle 1,
//    O_IF_ID_valid with pc=8000_0000 snpc=8000_0004 inst=00000297 fault=0.
//  2 Req ready delayed 3 cycles, rsp 2 more, I_IF_ID_ready=0 for 4 cycles -> addr/pc/inst
//    stable throughout; O_dnpc_ready rises only after IF/ID handshake.
//  3 Flush in WAIT, then dnpc=8000_0100 -> old response discarded (no IF_ID_valid);
//    next request addr 8000_0100.
//  4 dnpc=8000_0102 -> no bus request; O_IF_ID_valid=1, fault=1, inst=0000_0013, pc=8000_0102.
//  5 rsp_err=1 on fetch at 8000_0200 -> fault=1, inst=0000_0013; dnpc=FFFF_FFFC -> snpc=0.
//  6 Drop I_rst_n mid-WAIT -> all valids/readies 0 immediately; after release fetch RESET_PC.

Source files
------------

// File: rtl/ysyx_22040750_pc_fetch.sv
// ysyx_22040750_pc_fetch
// Instruction fetch front end. Owns the architectural PC, takes the next PC
// from the next-PC unit over a valid/ready link, issues exactly one
// instruction read at a time, and presents {pc, snpc, inst, fault} to the
// IF/ID register. A flush kills whatever instruction is queued, held or in
// flight. An in-flight bus read cannot be withdrawn, so its response is
// swallowed when it eventually arrives.
module ysyx_22040750_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        I_clk,
    input  logic        I_rst_n,

    // Next-PC link.
    input  logic [31:0] I_dnpc,
    input  logic        I_dnpc_valid,
    output logic        O_dnpc_ready,

    // Redirect kill.
    input  logic        I_flush,

    // Instruction bus, request channel.
    output logic        O_imem_req_valid,
    input  logic        I_imem_req_ready,
    output logic [31:0] O_imem_addr,

    // Instruction bus, response channel.
    input  logic        I_imem_rsp_valid,
    output logic        O_imem_rsp_ready,
    input  logic [31:0] I_imem_rsp_data,
    input  logic        I_imem_rsp_err,

    // IF/ID register link.
    output logic        O_IF_ID_valid,
    input  logic        I_IF_ID_ready,
    output logic [31:0] O_pc,
    output logic [31:0] O_snpc,
    output logic [31:0] O_inst,
    output logic        O_fault
);

    // REQ  : request for pc_q is on the bus, waiting for acceptance
    // WAIT : request accepted, waiting for the response
    // HOLD : instruction presented to IF/ID, waiting for the handshake
    // NEXT : waiting for the next PC from the next-PC unit
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_NEXT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] inst_q,  inst_d;
    logic        fault_q, fault_d;
    logic        drop_q,  drop_d;

    // Low for the first cycle after reset release. Reset leaves the FSM in
    // REQ, so without this the request would appear while reset is still
    // asserted instead of one cycle after release.
    logic        live_q;

    logic        req_fire;
    logic        rsp_fire;
    logic        dnpc_fire;
    logic        misaligned;

    // Output decode: everything comes from registers except IF/ID valid,
    // which a same-cycle flush must suppress.
    always_comb begin
        O_imem_req_valid = live_q && (state_q == S_REQ);
        O_imem_rsp_ready = (state_q == S_WAIT);
        O_dnpc_ready     = (state_q == S_NEXT);
        O_IF_ID_valid    = (state_q == S_HOLD) && !I_flush;
        O_imem_addr      = pc_q;
        O_pc             = pc_q;
        O_snpc           = pc_q + 32'd4;
        O_inst           = inst_q;
        O_fault          = fault_q;
    end

    // Handshake strobes shared by the next-state logic.
    always_comb begin
        req_fire   = O_imem_req_valid && I_imem_req_ready;
        rsp_fire   = O_imem_rsp_ready && I_imem_rsp_valid;
        dnpc_fire  = O_dnpc_ready && I_dnpc_valid;
        misaligned = (I_dnpc[1:0] != 2'b00);
    end

    // Next-state logic for the fetch FSM and its datapath registers.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no
        // path through the case statement can leave one unassigned and
        // infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        drop_d  = drop_q;

        unique case (state_q)
            S_REQ: begin
                // The request cannot be withdrawn once raised; a flush only
                // marks its eventual response for discard.
                if (I_flush) begin
                    drop_d = 1'b1;
                end
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (rsp_fire) begin
                    if (drop_q || I_flush) begin
                        // Killed fetch: swallow the data and ask for a new PC.
                        drop_d  = 1'b0;
                        state_d = S_NEXT;
                    end else begin
                        inst_d  = I_imem_rsp_err ? NOP_INST : I_imem_rsp_data;
                        fault_d = I_imem_rsp_err;
                        state_d = S_HOLD;
                    end
                end else if (I_flush) begin
                    drop_d = 1'b1;
                end
            end

            S_HOLD: begin
                // Flush wins over a same-cycle IF/ID ready; both leave HOLD.
                if (I_flush || I_IF_ID_ready) begin
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                if (dnpc_fire) begin
                    pc_d = I_dnpc;
                    if (misaligned) begin
                        // Never put a misaligned address on the bus; present
                        // a faulting NOP instead.
                        inst_d  = NOP_INST;
                        fault_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        fault_d = 1'b0;
                        state_d = S_REQ;
                    end
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            fault_q <= 1'b0;
            drop_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            drop_q  <= drop_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_22040750_pc_fetch.sv
// tb_ysyx_22040750_pc_fetch
// Self-checking bench: reset behaviour, a table of fetch vectors with
// hand-computed expectations, hand-written flush/stall/reset sequences, and
// a randomized run compared against a behavioural model.
module tb_ysyx_22040750_pc_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dnpc;
    logic        dnpc_valid;
    logic        dnpc_ready;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        ifid_valid;
    logic        ifid_ready;
    logic [31:0] pc;
    logic [31:0] snpc;
    logic [31:0] inst;
    logic        fault;

    always #5 clk = ~clk;

    ysyx_22040750_pc_fetch #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) dut (
        .I_clk            (clk),
        .I_rst_n          (rst_n),
        .I_dnpc           (dnpc),
        .I_dnpc_valid     (dnpc_valid),
        .O_dnpc_ready     (dnpc_ready),
        .I_flush          (flush),
        .O_imem_req_valid (req_valid),
        .I_imem_req_ready (req_ready),
        .O_imem_addr      (addr),
        .I_imem_rsp_valid (rsp_valid),
        .O_imem_rsp_ready (rsp_ready),
        .I_imem_rsp_data  (rsp_data),
        .I_imem_rsp_err   (rsp_err),
        .O_IF_ID_valid    (ifid_valid),
        .I_IF_ID_ready    (ifid_ready),
        .O_pc             (pc),
        .O_snpc           (snpc),
        .O_inst           (inst),
        .O_fault          (fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] snpc;
        logic [31:0] inst;
        logic        fault;
    } pres_t;

    typedef struct {
        logic [31:0] dnpc;
        logic [31:0] data;
        logic        err;
        logic        bus;
        logic [31:0] e_pc;
        logic [31:0] e_snpc;
        logic [31:0] e_inst;
        logic        e_fault;
    } vec_t;

    int    n_total = 0;
    int    n_pass  = 0;
    vec_t  vecs[8];
    pres_t exp_q[$];
    pres_t p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // What the IF/ID register should see for a fetch of address a.
    function automatic pres_t model(input logic [31:0] a, input logic [31:0] data, input logic err);
        pres_t r;
        r.pc    = a;
        r.snpc  = a + 32'd4;
        r.fault = (a[1:0] != 2'b00) || err;
        r.inst  = r.fault ? NOP : data;
        return r;
    endfunction

    // Offer a next PC; optionally flush in the accepting cycle.
    task automatic send_dnpc(input logic [31:0] a, input logic fl);
        int n;
        n = 0;
        dnpc       = a;
        dnpc_valid = 1'b1;
        while (!dnpc_ready && n < 50) begin
            tick();
            n++;
        end
        check1("dnpc_ready_seen", dnpc_ready, 1'b1);
        flush = fl;
        tick();
        dnpc_valid = 1'b0;
        flush      = 1'b0;
        dnpc       = $urandom;
    endtask

    // Serve one bus read with given delays; optional flush in WAIT or with the response.
    task automatic serve(input int req_dly, input int rsp_dly, input logic [31:0] data,
                         input logic err, input logic fl_wait, input logic fl_same,
                         input logic [31:0] exp_addr);
        int n;
        n = 0;
        while (!req_valid && n < 50) begin
            tick();
            n++;
        end
        check1("req_seen", req_valid, 1'b1);
        check("req_addr", addr, exp_addr);
        for (int i = 0; i < req_dly; i++) begin
            tick();
            check1("req_hold_valid", req_valid, 1'b1);
            check("req_hold_addr", addr, exp_addr);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check1("rsp_ready_wait", rsp_ready, 1'b1);
        if (fl_wait) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        for (int i = 0; i < rsp_dly; i++) begin
            check1("no_req_in_wait", req_valid, 1'b0);
            tick();
        end
        rsp_valid = 1'b1;
        rsp_data  = data;
        rsp_err   = err;
        flush     = fl_same;
        tick();
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        flush     = 1'b0;
        rsp_data  = $urandom;
    endtask

    // Check the presented instruction, stall IF/ID, then take it.
    task automatic present(input pres_t e, input int stall);
        check1("ifid_valid", ifid_valid, 1'b1);
        check("pc", pc, e.pc);
        check("snpc", snpc, e.snpc);
        check("inst", inst, e.inst);
        check1("fault", fault, e.fault);
        for (int i = 0; i < stall; i++) begin
            check1("stall_dnpc_ready", dnpc_ready, 1'b0);
            tick();
            check1("stall_valid", ifid_valid, 1'b1);
            check("stall_pc", pc, e.pc);
            check("stall_inst", inst, e.inst);
            check1("stall_req", req_valid, 1'b0);
        end
        ifid_ready = 1'b1;
        tick();
        ifid_ready = 1'b0;
        check1("post_hs_dnpc_ready", dnpc_ready, 1'b1);
        check1("post_hs_valid", ifid_valid, 1'b0);
    endtask

    // A killed fetch must end in NEXT without ever presenting.
    task automatic expect_dropped();
        check1("drop_dnpc_ready", dnpc_ready, 1'b1);
        check1("drop_valid", ifid_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] data;
        logic        err;
        logic        flw;

        vecs[0] = '{32'h8000_0004, 32'h0010_0073, 1'b0, 1'b1, 32'h8000_0004, 32'h8000_0008, 32'h0010_0073, 1'b0};
        vecs[1] = '{32'h8000_0102, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0102, 32'h8000_0106, 32'h0000_0013, 1'b1};
        vecs[2] = '{32'h8000_0200, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h8000_0200, 32'h8000_0204, 32'h0000_0013, 1'b1};
        vecs[3] = '{32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vecs[4] = '{32'h8000_0001, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0001, 32'h8000_0005, 32'h0000_0013, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'hAAAA_5555, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'hAAAA_5555, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0013, 1'b1};
        vecs[7] = '{32'h8000_0008, 32'h0000_0513, 1'b0, 1'b1, 32'h8000_0008, 32'h8000_000C, 32'h0000_0513, 1'b0};

        rst_n      = 1'b0;
        dnpc       = '0;
        dnpc_valid = 1'b0;
        flush      = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        rsp_err    = 1'b0;
        ifid_ready = 1'b0;

        // Reset state.
        tick();
        tick();
        check1("rst_req_valid", req_valid, 1'b0);
        check1("rst_rsp_ready", rsp_ready, 1'b0);
        check1("rst_dnpc_ready", dnpc_ready, 1'b0);
        check1("rst_ifid_valid", ifid_valid, 1'b0);
        check("rst_pc", pc, RESET_PC);
        check("rst_inst", inst, 32'h0);
        check1("rst_fault", fault, 1'b0);

        // First fetch after release, zero-wait bus.
        rst_n = 1'b1;
        #1;
        check1("rel_req_cycle0", req_valid, 1'b0);
        tick();
        check1("rel_req_cycle1", req_valid, 1'b1);
        check("rel_addr", addr, RESET_PC);
        serve(0, 0, 32'h0000_0297, 1'b0, 1'b0, 1'b0, RESET_PC);
        present('{32'h8000_0000, 32'h8000_0004, 32'h0000_0297, 1'b0}, 0);

        // Slow bus and stalled IF/ID.
        send_dnpc(32'h8000_0010, 1'b0);
        serve(3, 2, 32'h00A0_0093, 1'b0, 1'b0, 1'b0, 32'h8000_0010);
        present('{32'h8000_0010, 32'h8000_0014, 32'h00A0_0093, 1'b0}, 4);

        // Table of single fetches.
        for (int i = 0; i < 8; i++) begin
            send_dnpc(vecs[i].dnpc, 1'b0);
            if (vecs[i].bus) serve(0, 0, vecs[i].data, vecs[i].err, 1'b0, 1'b0, vecs[i].dnpc);
            else check1("vec_no_req", req_valid, 1'b0);
            p.pc    = vecs[i].e_pc;
            p.snpc  = vecs[i].e_snpc;
            p.inst  = vecs[i].e_inst;
            p.fault = vecs[i].e_fault;
            present(p, 0);
        end

        // Flush in WAIT, then redirect.
        send_dnpc(32'h8000_0300, 1'b0);
        serve(0, 1, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 32'h8000_0300);
        expect_dropped();
        send_dnpc(32'h8000_0100, 1'b0);
        serve(0, 0, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 32'h8000_0100);
        present('{32'h8000_0100, 32'h8000_0104, 32'h2222_2222, 1'b0}, 0);

        // Flush together with the response.
        send_dnpc(32'h8000_0500, 1'b0);
        serve(0, 0, 32'h3333_3333, 1'b0, 1'b0, 1'b1, 32'h8000_0500);
        expect_dropped();

        // Flush in REQ: request stays up, response is discarded.
        send_dnpc(32'h8000_0600, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check1("req_flush_kept", req_valid, 1'b1);
        check("req_flush_addr", addr, 32'h8000_0600);
        serve(0, 0, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 32'h8000_0600);
        expect_dropped();

        // Flush in HOLD beats a same-cycle IF/ID ready.
        send_dnpc(32'h8000_0700, 1'b0);
        serve(0, 0, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 32'h8000_0700);
        check1("hold_valid_pre", ifid_valid, 1'b1);
        flush      = 1'b1;
        ifid_ready = 1'b1;
        #1;
        check1("hold_flush_valid", ifid_valid, 1'b0);
        tick();
        flush      = 1'b0;
        ifid_ready = 1'b0;
        expect_dropped();

        // Flush in NEXT has no effect on the accepted PC.
        send_dnpc(32'h8000_0800, 1'b1);
        serve(0, 0, 32'h6666_6666, 1'b0, 1'b0, 1'b0, 32'h8000_0800);
        present('{32'h8000_0800, 32'h8000_0804, 32'h6666_6666, 1'b0}, 0);

        // Randomized run against the model.
        for (int it = 0; it < 40; it++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            data = $urandom;
            err  = ($urandom_range(0, 3) == 0);
            flw  = (a[1:0] == 2'b00) && ($urandom_range(0, 4) == 0);
            send_dnpc(a, 1'b0);
            if (a[1:0] != 2'b00) check1("rnd_no_req", req_valid, 1'b0);
            else serve($urandom_range(0, 2), $urandom_range(0, 2), data, err, flw, 1'b0, a);
            if (flw) begin
                expect_dropped();
            end else begin
                exp_q.push_back(model(a, data, err));
                present(exp_q.pop_front(), $urandom_range(0, 2));
            end
        end

        // Reset asserted mid-WAIT.
        send_dnpc(32'h8000_0900, 1'b0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check1("pre_rst_wait", rsp_ready, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check1("mid_rst_req_valid", req_valid, 1'b0);
        check1("mid_rst_rsp_ready", rsp_ready, 1'b0);
        check1("mid_rst_dnpc_ready", dnpc_ready, 1'b0);
        check1("mid_rst_ifid_valid", ifid_valid, 1'b0);
        check("mid_rst_pc", pc, RESET_PC);
        tick();
        rst_n = 1'b1;
        #1;
        check1("rel2_req_cycle0", req_valid, 1'b0);
        tick();
        check1("rel2_req_cycle1", req_valid, 1'b1);
        serve(0, 0, 32'h7777_7777, 1'b0, 1'b0, 1'b0, RESET_PC);
        present('{32'h8000_0000, 32'h8000_0004, 32'h7777_7777, 1'b0}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
